// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and default widths shared by the ALU, the UART command decoder and the bench
package alu_pkg;
  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF = 6;
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode bus into the ALU and registered result back out
interface alu_if import alu_pkg::*; #(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP = NB_OP_DEF
);
  logic [NB_DATA-1:0] i_dataA;
  logic [NB_DATA-1:0] i_dataB;
  logic [NB_OP-1:0] i_op;
  logic [NB_DATA-1:0] o_result;
  logic o_overflow;
  modport master (output i_dataA, i_dataB, i_op, input o_result, o_overflow);
  modport slave (input i_dataA, i_dataB, i_op, output o_result, o_overflow);
endinterface

// File: rtl/alu_comb.sv
// alu_comb: combinational result and signed-overflow generation for MIPS-style funct codes
module alu_comb import alu_pkg::*; #(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP = NB_OP_DEF
) (
  input  logic [NB_DATA-1:0] a,
  input  logic [NB_DATA-1:0] b,
  input  logic [NB_OP-1:0]   op,
  output logic [NB_DATA-1:0] result,
  output logic               overflow
);
  localparam int MSB = NB_DATA - 1;
  logic [NB_DATA-1:0] sum;
  logic [NB_DATA-1:0] diff;
  assign sum = a + b;
  assign diff = a - b;
  always_comb begin
    result = '0;
    overflow = 1'b0;
    case (op)
      NB_OP'(ADD): begin
        result = sum;
        overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      NB_OP'(SUB): begin
        result = diff;
        overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      NB_OP'(AND): result = a & b;
      NB_OP'(OR):  result = a | b;
      NB_OP'(XOR): result = a ^ b;
      NB_OP'(NOR): result = ~(a | b);
      // full-width shift amount: oversize shifts saturate to sign fill / zero
      NB_OP'(SRA): result = $signed(a) >>> b;
      NB_OP'(SRL): result = a >> b;
      default: ;
    endcase
  end
endmodule

// File: rtl/alu.sv
// alu: registered integer ALU; the combinational core feeds a resettable output stage
module alu import alu_pkg::*; #(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP = NB_OP_DEF
) (
  input logic i_clk,
  input logic i_reset,
  alu_if.slave bus
);
  logic [NB_DATA-1:0] result;
  logic overflow;
  alu_comb #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_comb (
    .a(bus.i_dataA),
    .b(bus.i_dataB),
    .op(bus.i_op),
    .result(result),
    .overflow(overflow)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_result <= '0;
      bus.o_overflow <= 1'b0;
    end else begin
      bus.o_result <= result;
      bus.o_overflow <= overflow;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with a queue scoreboard; a monitor checks each result one edge after issue
module tb_alu;
  import alu_pkg::*;
  typedef struct {
    string name;
    logic [7:0] res;
    logic ovf;
  } exp_t;
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  alu_if #(.NB_DATA(8), .NB_OP(6)) bus ();
  alu #(.NB_DATA(8), .NB_OP(6)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));
  always #5 i_clk = ~i_clk;
  task automatic issue(input string name, input logic rst, input logic [5:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic ovf);
    exp_t e;
    @(negedge i_clk);
    i_reset = rst;
    bus.i_op = op;
    bus.i_dataA = a;
    bus.i_dataB = b;
    e.name = name;
    e.res = res;
    e.ovf = ovf;
    sb.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tests++;
        if (bus.o_result !== e.res || bus.o_overflow !== e.ovf) begin
          fails++;
          $display("FAIL %s: got result=%02h ovf=%b, expected result=%02h ovf=%b",
                   e.name, bus.o_result, bus.o_overflow, e.res, e.ovf);
        end
      end
    end
  end
  initial begin
    int wait_cyc;
    bus.i_op = ADD;
    bus.i_dataA = 8'h00;
    bus.i_dataB = 8'h00;
    issue("reset_add", 1'b1, ADD, 8'h05, 8'h03, 8'h00, 1'b0);
    issue("post_reset_add", 1'b0, ADD, 8'h05, 8'h03, 8'h08, 1'b0);
    issue("add_ovf", 1'b0, ADD, 8'h7F, 8'h01, 8'h80, 1'b1);
    issue("add_wrap", 1'b0, ADD, 8'hFF, 8'h01, 8'h00, 1'b0);
    issue("sub_ovf", 1'b0, SUB, 8'h80, 8'h01, 8'h7F, 1'b1);
    issue("sub_neg", 1'b0, SUB, 8'h05, 8'h07, 8'hFE, 1'b0);
    issue("and", 1'b0, AND, 8'h0F, 8'hF5, 8'h05, 1'b0);
    issue("or", 1'b0, OR, 8'h0F, 8'hF5, 8'hFF, 1'b0);
    issue("xor", 1'b0, XOR, 8'h0F, 8'hF5, 8'hFA, 1'b0);
    issue("nor", 1'b0, NOR, 8'h0F, 8'hF5, 8'h00, 1'b0);
    issue("sra_2", 1'b0, SRA, 8'h90, 8'h02, 8'hE4, 1'b0);
    issue("srl_2", 1'b0, SRL, 8'h90, 8'h02, 8'h24, 1'b0);
    issue("sra_9", 1'b0, SRA, 8'h90, 8'h09, 8'hFF, 1'b0);
    issue("srl_8", 1'b0, SRL, 8'h90, 8'h08, 8'h00, 1'b0);
    issue("sra_0", 1'b0, SRA, 8'h70, 8'h00, 8'h70, 1'b0);
    issue("invalid_op", 1'b0, 6'b111111, 8'h12, 8'h34, 8'h00, 1'b0);
    issue("midstream_reset", 1'b1, SUB, 8'h80, 8'h01, 8'h00, 1'b0);
    issue("b2b_add", 1'b0, ADD, 8'h3C, 8'h0A, 8'h46, 1'b0);
    issue("b2b_sub", 1'b0, SUB, 8'h3C, 8'h0A, 8'h32, 1'b0);
    issue("b2b_and", 1'b0, AND, 8'h3C, 8'h0A, 8'h08, 1'b0);
    issue("b2b_or", 1'b0, OR, 8'h3C, 8'h0A, 8'h3E, 1'b0);
    issue("b2b_xor", 1'b0, XOR, 8'h3C, 8'h0A, 8'h36, 1'b0);
    issue("b2b_nor", 1'b0, NOR, 8'h3C, 8'h0A, 8'hC1, 1'b0);
    issue("b2b_sra", 1'b0, SRA, 8'hC4, 8'h03, 8'hF8, 1'b0);
    issue("b2b_srl", 1'b0, SRL, 8'hC4, 8'h03, 8'h18, 1'b0);
    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 10) begin
      @(posedge i_clk);
      wait_cyc++;
    end
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
